// File: rtl/piso_frame_tx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : piso_frame_tx
// Purpose  : Parallel-in / serial-out framing transmitter. Accepts a word over
//            a valid/ready handshake and sends it on a single line as
//            start bit, data bits (selectable order), optional even parity
//            and stop bit. Each serial bit is held for CLKS_PER_BIT cycles.
// Revision : 1.0 - initial release
// ============================================================================
module piso_frame_tx #(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 4,
  parameter int PARITY_EN    = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              lsb_first,
  output logic              in_ready,
  output logic              ser_out,
  output logic              busy,
  output logic              done
);

  // Counter widths never collapse to zero, so CLKS_PER_BIT=1 and DATA_W=1
  // still yield legal one-bit counters.
  localparam int CYC_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  localparam logic [CYC_W-1:0] C_CYC_LAST = CYC_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] C_BIT_LAST = BIT_W'(DATA_W - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic              lsb_q, lsb_d;
  logic              par_q, par_d;
  logic [CYC_W-1:0]  cyc_q, cyc_d;
  logic [BIT_W-1:0]  bit_q, bit_d;
  logic              ser_out_q, ser_out_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic              w_bit_end;
  logic              w_next_data_bit;

  // The handshake is open whenever no frame is in flight.
  assign in_ready  = (state_q == S_IDLE);

  // Last cycle of the current serial bit period.
  assign w_bit_end = (cyc_q == C_CYC_LAST);

  // Frame sequencing: next state, shift register, bit/cycle counters, done.
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    lsb_d   = lsb_q;
    par_d   = par_q;
    cyc_d   = cyc_q;
    bit_d   = bit_q;
    done_d  = 1'b0;

    // Bit-period counter runs in every active state and wraps each bit.
    if (state_q != S_IDLE) begin
      if (w_bit_end) begin
        cyc_d = '0;
      end else begin
        cyc_d = cyc_q + 1'b1;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          state_d = S_START;
          shreg_d = in_data;
          lsb_d   = lsb_first;
          par_d   = ^in_data;
          cyc_d   = '0;
          bit_d   = '0;
        end
      end

      S_START: begin
        if (w_bit_end) begin
          state_d = S_DATA;
        end
      end

      S_DATA: begin
        if (w_bit_end) begin
          // Consume the bit just sent; vacated positions fill with zero.
          if (lsb_q) begin
            shreg_d = shreg_q >> 1;
          end else begin
            shreg_d = shreg_q << 1;
          end
          if (bit_q == C_BIT_LAST) begin
            bit_d   = '0;
            state_d = (PARITY_EN != 0) ? S_PARITY : S_STOP;
          end else begin
            bit_d   = bit_q + 1'b1;
          end
        end
      end

      S_PARITY: begin
        if (w_bit_end) begin
          state_d = S_STOP;
        end
      end

      S_STOP: begin
        if (w_bit_end) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // The line level is decided from the upcoming state so that ser_out can be
  // registered yet still drop on the very cycle after accept.
  assign w_next_data_bit = lsb_d ? shreg_d[0] : shreg_d[DATA_W-1];

  // Registered-output decode: line level and busy for the coming cycle.
  always_comb begin
    ser_out_d = 1'b1;
    busy_d    = (state_d != S_IDLE);
    case (state_d)
      S_IDLE:   ser_out_d = 1'b1;
      S_START:  ser_out_d = 1'b0;
      S_DATA:   ser_out_d = w_next_data_bit;
      S_PARITY: ser_out_d = par_d;
      S_STOP:   ser_out_d = 1'b1;
      default:  ser_out_d = 1'b1;
    endcase
  end

  // State and datapath registers; reset aborts any frame immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      shreg_q   <= '0;
      lsb_q     <= 1'b0;
      par_q     <= 1'b0;
      cyc_q     <= '0;
      bit_q     <= '0;
      ser_out_q <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      lsb_q     <= lsb_d;
      par_q     <= par_d;
      cyc_q     <= cyc_d;
      bit_q     <= bit_d;
      ser_out_q <= ser_out_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign ser_out = ser_out_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule
`default_nettype wire

// File: doc/piso_frame_tx.md
Name: piso_frame_tx

Overview:
- Parallel-in/serial-out framing transmitter that consumes the 8-bit word held in the universal shift register stage and emits it as an asynchronous-style serial frame: start bit, data bits, optional parity, stop bit.
- Sits directly downstream of the shift-register stage.
- Uses a valid/ready handshake on the parallel side and a per-bit clock-divider counter on the serial side.

Parameters:
- DATA_W, 8, data bits per frame (≥1).
- CLKS_PER_BIT, 4, clk cycles each serial bit is held (≥1).
- PARITY_EN, 0, 1 inserts an even-parity bit after the data bits; 0 omits it.

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  in_data is offered this cycle.
- in_data  input  DATA_W  parallel word to transmit.
- lsb_first  input  1  bit order, sampled at accept; 1 = bit 0 first, 0 = bit DATA_W-1 first.
- in_ready  output  1  block can accept a word this cycle.
- ser_out  output  1  serial line; idles high.
- busy  output  1  frame in progress.
- done  output  1  one-cycle pulse when a frame completes.

Behaviour:
- Reset values (asynchronous, active-high): state=IDLE, ser_out=1, busy=0, done=0, in_ready=1, internal shift/bit/cycle counters=0.
- Reset asserted mid-frame aborts immediately. ser_out returns to 1 asynchronously. No done pulse is generated.
- in_ready is 1 exactly when state==IDLE. It is combinational from state.
- Accept: in_valid && in_ready at a rising edge. On accept:
  - latch in_data into an internal shift register;
  - latch lsb_first;
  - compute parity = XOR of in_data;
  - go to START.
- in_valid while in_ready=0 is ignored. The latched word is unaffected.
- States:
  - IDLE: ser_out=1, busy=0.
  - START: ser_out=0 for CLKS_PER_BIT cycles → DATA.
  - DATA: ser_out = current data bit, held CLKS_PER_BIT cycles per bit.
    - Shift register advances by one after each bit: right shift when lsb_first=1, left shift when 0.
    - After DATA_W bits → PARITY if PARITY_EN, else STOP.
  - PARITY: ser_out = even-parity bit, so total ones over data+parity is even. Held CLKS_PER_BIT cycles → STOP.
  - STOP: ser_out=1 for CLKS_PER_BIT cycles → IDLE.
- ser_out and busy are registered. ser_out goes low the cycle after accept. busy=1 in every non-IDLE state.
- Frame length: (2 + DATA_W + PARITY_EN) × CLKS_PER_BIT cycles, measured from the cycle after accept.
- done pulses high for exactly one cycle: the first IDLE cycle after STOP. in_ready is also 1 in that cycle.
- Back-to-back: a word accepted in the done cycle starts START on the next cycle. There is no idle gap beyond that one cycle.
- Cycle counter counts 0..CLKS_PER_BIT-1 and wraps. Its width is max(1, clog2(CLKS_PER_BIT)).
- CLKS_PER_BIT=1 must work: one cycle per bit.
- Bit counter counts 0..DATA_W-1.
- No X on any output after reset. Unused shift-register bits shift in 0.

Test Plan:
- Reset, then idle 5 cycles → ser_out=1, busy=0, in_ready=1, done=0 throughout.
- CLKS_PER_BIT=4, PARITY_EN=0, accept in_data=8'hD3 with lsb_first=0 → ser_out per 4-cycle bit: 0, 1,1,0,1,0,0,1,1, 1. Total 40 cycles busy=1. done=1 for one cycle at cycle 41 after accept.
- Same word with lsb_first=1 → data bits 1,1,0,0,1,0,1,1 between start 0 and stop 1.
- PARITY_EN=1, CLKS_PER_BIT=1, in_data=8'hD3 (five ones), lsb_first=0 → bit sequence 0,1,1,0,1,0,0,1,1,1(parity),1(stop). Frame is 11 cycles.
- Hold in_valid=1 with 8'hA5 then 8'h3C continuously → second word accepted only in the done cycle of the first. in_valid during busy does not corrupt the first frame. Second frame's start bit is on the following cycle.
- Assert reset at cycle 15 of a frame → ser_out=1 and busy=0 immediately, no done pulse. After release, a new 8'h01 frame transmits correctly.
